lift_motion_ctrl: RTL

LIFT_MOTION_CTRL -- requirements
Module: lift_motion_ctrl

---
 rtl/lift_pkg.sv | 27 ++
 rtl/lift_cycle_timer.sv | 24 ++
 rtl/lift_motion_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// Shared lift definitions: command encodings, controller states and floor limits.
package lift_pkg;

  typedef enum logic [1:0] {
    CMD_UP   = 2'b00,
    CMD_DOWN = 2'b01,
    CMD_STAY = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MOVE = 2'b01,
    ST_DOOR = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  localparam logic [1:0] FLOOR_MIN = 2'd0;
  localparam logic [1:0] FLOOR_MAX = 2'd3;

  function automatic logic cmd_legal(input cmd_e c, input logic [1:0] fl);
    return (c == CMD_UP   && fl != FLOOR_MAX) ||
           (c == CMD_DOWN && fl != FLOOR_MIN) ||
           (c == CMD_STAY);
  endfunction

endpackage

// File: rtl/lift_cycle_timer.sv
// 8-bit down-counter with synchronous load; holds at zero and flags it.
module lift_cycle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lift_motion_ctrl.sv
// Lift motion controller: IDLE/MOVE/DOOR/FIN sequencing of motor and door drives.
// Optional door re-open on obstruction: define LIFT_DOOR_REOPEN_EN.
module lift_motion_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned TRAVEL_CYC = 8,
  parameter int unsigned DOOR_CYC   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cmd,
  input  logic       cmd_valid,
  input  logic       door_obst,
  output logic [1:0] floor,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       door_open,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  localparam logic [7:0] TRAVEL_LD = 8'(TRAVEL_CYC - 1);
  localparam logic [7:0] DOOR_LD   = 8'(DOOR_CYC - 1);

  state_e     state_q;
  logic [1:0] floor_q;
  logic       dir_up_q, err_q;
  logic       motor_up_q, motor_dn_q, door_open_q, busy_q, done_q, cmd_err_q;
  logic       tmr_load_d, tmr_zero, reopen;
  logic [7:0] tmr_val_d;
  cmd_e       cmd_in;

  assign cmd_in = cmd_e'(cmd);

`ifdef LIFT_DOOR_REOPEN_EN
  assign reopen = (state_q == ST_DOOR) && door_obst;
`else
  assign reopen = 1'b0 & door_obst;
`endif

  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = '0;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) begin
        tmr_load_d = 1'b1;
        if (!cmd_legal(cmd_in, floor_q)) tmr_val_d = '0;
        else if (cmd_in == CMD_STAY)     tmr_val_d = DOOR_LD;
        else                             tmr_val_d = TRAVEL_LD;
      end
      ST_MOVE: if (tmr_zero && !err_q) begin
        tmr_load_d = 1'b1;
        tmr_val_d  = DOOR_LD;
      end
      ST_DOOR: if (reopen) begin
        tmr_load_d = 1'b1;
        tmr_val_d  = DOOR_LD;
      end
      default: ;
    endcase
  end

  lift_cycle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .zero_o     (tmr_zero)
  );

  // A rejected command spends one motor-less MOVE beat (timer preloaded to 0)
  // so its done/cmd_err pulse lands exactly one edge after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      floor_q     <= FLOOR_MIN;
      dir_up_q    <= 1'b0;
      err_q       <= 1'b0;
      motor_up_q  <= 1'b0;
      motor_dn_q  <= 1'b0;
      door_open_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (cmd_valid) begin
          busy_q <= 1'b1;
          if (!cmd_legal(cmd_in, floor_q)) begin
            state_q <= ST_MOVE;
            err_q   <= 1'b1;
          end else if (cmd_in == CMD_STAY) begin
            state_q     <= ST_DOOR;
            door_open_q <= 1'b1;
          end else begin
            state_q    <= ST_MOVE;
            dir_up_q   <= (cmd_in == CMD_UP);
            motor_up_q <= (cmd_in == CMD_UP);
            motor_dn_q <= (cmd_in == CMD_DOWN);
          end
        end
        ST_MOVE: if (tmr_zero) begin
          motor_up_q <= 1'b0;
          motor_dn_q <= 1'b0;
          if (err_q) begin
            state_q   <= ST_FIN;
            err_q     <= 1'b0;
            done_q    <= 1'b1;
            cmd_err_q <= 1'b1;
          end else begin
            state_q     <= ST_DOOR;
            door_open_q <= 1'b1;
            if (dir_up_q && floor_q != FLOOR_MAX)       floor_q <= floor_q + 2'd1;
            else if (!dir_up_q && floor_q != FLOOR_MIN) floor_q <= floor_q - 2'd1;
          end
        end
        ST_DOOR: if (tmr_zero && !reopen) begin
          state_q     <= ST_FIN;
          door_open_q <= 1'b0;
          done_q      <= 1'b1;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign floor     = floor_q;
  assign motor_up  = motor_up_q;
  assign motor_dn  = motor_dn_q;
  assign door_open = door_open_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;

endmodule
